// File: rtl/sbox_share_sched.sv
`default_nettype none
// ============================================================================
//  Module   : sbox_share_sched
//  Brief    : Shares NUM_SBOX combinational AES S-box lookups between a
//             128-bit SubBytes requester and a 32-bit SubWord requester.
//             Round-robin arbitration, beat sequencing, registered results.
//  Options  : `define SBOX_SHARE_PERF_EN to build the oStallCnt counter.
//  Revision : 1.0 - initial release
// ============================================================================
module sbox_share_sched #(
    parameter int NUM_SBOX = 4
) (
    input  logic         iClk,
    input  logic         iRsn,
    input  logic         iStValid,
    output logic         oStReady,
    input  logic [127:0] iStData,
    output logic [127:0] oStData,
    output logic         oStDone,
    input  logic         iKwValid,
    output logic         oKwReady,
    input  logic [31:0]  iKwData,
    output logic [31:0]  oKwData,
    output logic         oKwDone,
    output logic         oBusy,
    output logic [15:0]  oStallCnt
);

    localparam int c_BEATS_ST = 16 / NUM_SBOX;
    localparam int c_BEATS_KW = 4 / NUM_SBOX;
    localparam int c_CNT_W    = (c_BEATS_ST > 1) ? $clog2(c_BEATS_ST) : 1;
    localparam int c_LANE_SH  = $clog2(NUM_SBOX);
    localparam logic [c_CNT_W-1:0] c_LAST_ST = c_CNT_W'(c_BEATS_ST - 1);
    localparam logic [c_CNT_W-1:0] c_LAST_KW = c_CNT_W'(c_BEATS_KW - 1);

    generate
        if (NUM_SBOX != 1 && NUM_SBOX != 2 && NUM_SBOX != 4) begin : g_bad_num_sbox
            $error("sbox_share_sched: NUM_SBOX must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN_ST = 2'd1,
        RUN_KW = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_CNT_W-1:0]     r_beat;
    logic                   r_last_kw;      // 1: last grant went to the key-word path
    logic [127:0]           r_st_cap;
    logic [31:0]            r_kw_cap;
    logic [127:0]           r_st_data;
    logic [31:0]            r_kw_data;
    logic                   w_st_ready;
    logic                   w_kw_ready;
    logic [3:0]             w_base;
    logic [3:0]             w_lane_idx [NUM_SBOX];
    logic [7:0]             w_lane_in;
    logic [NUM_SBOX*8-1:0]  w_sb_out;

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // AES S-box: inverse as x^254 (0 maps to 0), then the affine transform
    function automatic logic [7:0] sbox_fn(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // Shared lookup lanes: lane j handles captured byte beat*NUM_SBOX + j
    always_comb begin
        w_base    = 4'(r_beat) << c_LANE_SH;
        w_lane_in = 8'h00;
        w_sb_out  = '0;
        for (int j = 0; j < NUM_SBOX; j++) begin
            w_lane_idx[j] = w_base | 4'(j);
            w_lane_in     = (r_state == RUN_KW) ? r_kw_cap[8*w_lane_idx[j][1:0] +: 8]
                                                : r_st_cap[8*w_lane_idx[j] +: 8];
            w_sb_out[8*j +: 8] = sbox_fn(w_lane_in);
        end
    end

    // FSM state register
    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state and round-robin handshake; requests are only taken in IDLE
    always_comb begin
        w_state_nxt = r_state;
        w_st_ready  = 1'b0;
        w_kw_ready  = 1'b0;
        case (r_state)
            IDLE: begin
                w_st_ready = iStValid & (~iKwValid | r_last_kw);
                w_kw_ready = iKwValid & (~iStValid | ~r_last_kw);
                if (w_st_ready)      w_state_nxt = RUN_ST;
                else if (w_kw_ready) w_state_nxt = RUN_KW;
            end
            RUN_ST:  if (r_beat == c_LAST_ST) w_state_nxt = DONE;
            RUN_KW:  if (r_beat == c_LAST_KW) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Capture on accept, step beats, and write lookup results into outputs
    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            r_beat    <= '0;
            r_last_kw <= 1'b0;
            r_st_cap  <= '0;
            r_kw_cap  <= '0;
            r_st_data <= '0;
            r_kw_data <= '0;
        end else begin
            if (w_st_ready) begin
                r_st_cap  <= iStData;
                r_beat    <= '0;
                r_last_kw <= 1'b0;
            end else if (w_kw_ready) begin
                r_kw_cap  <= iKwData;
                r_beat    <= '0;
                r_last_kw <= 1'b1;
            end else if (r_state == RUN_ST || r_state == RUN_KW) begin
                r_beat <= r_beat + 1'b1;
            end
            if (r_state == RUN_ST) begin
                for (int j = 0; j < NUM_SBOX; j++)
                    r_st_data[8*w_lane_idx[j] +: 8] <= w_sb_out[8*j +: 8];
            end
            if (r_state == RUN_KW) begin
                for (int j = 0; j < NUM_SBOX; j++)
                    r_kw_data[8*w_lane_idx[j][1:0] +: 8] <= w_sb_out[8*j +: 8];
            end
        end
    end

    assign oStReady = w_st_ready;
    assign oKwReady = w_kw_ready;
    assign oStData  = r_st_data;
    assign oKwData  = r_kw_data;
    assign oStDone  = (r_state == DONE) & ~r_last_kw;
    assign oKwDone  = (r_state == DONE) &  r_last_kw;
    assign oBusy    = (r_state != IDLE);

`ifdef SBOX_SHARE_PERF_EN
    logic [15:0] r_stall_cnt;
    logic        w_stall;
    assign w_stall = (iStValid & ~w_st_ready) | (iKwValid & ~w_kw_ready);

    // Saturating count of cycles in which some requester waits
    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn)                                 r_stall_cnt <= 16'h0000;
        else if (w_stall && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'h0001;
    end
    assign oStallCnt = r_stall_cnt;
`else
    assign oStallCnt = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sbox_share_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sbox_share_sched
//  Brief    : Self-checking bench for sbox_share_sched (NUM_SBOX 4, 1, 2).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sbox_share_sched;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         st_valid = 0, kw_valid = 0, a_st_valid = 0, a_kw_valid = 0;
    logic [127:0] st_data = '0;
    logic [31:0]  kw_data = '0;

    logic st_ready, kw_ready, st_done, kw_done, busy;
    logic [127:0] st_out; logic [31:0] kw_out; logic [15:0] stall_cnt;
    logic st_ready1, kw_ready1, st_done1, kw_done1, busy1;
    logic [127:0] st_out1; logic [31:0] kw_out1; logic [15:0] stall1;
    logic st_ready2, kw_ready2, st_done2, kw_done2, busy2;
    logic [127:0] st_out2; logic [31:0] kw_out2; logic [15:0] stall2;

    sbox_share_sched #(.NUM_SBOX(4)) u_dut (
        .iClk(clk), .iRsn(rst_n), .iStValid(st_valid), .oStReady(st_ready),
        .iStData(st_data), .oStData(st_out), .oStDone(st_done),
        .iKwValid(kw_valid), .oKwReady(kw_ready), .iKwData(kw_data),
        .oKwData(kw_out), .oKwDone(kw_done), .oBusy(busy), .oStallCnt(stall_cnt));

    sbox_share_sched #(.NUM_SBOX(1)) u_dut1 (
        .iClk(clk), .iRsn(rst_n), .iStValid(a_st_valid), .oStReady(st_ready1),
        .iStData(st_data), .oStData(st_out1), .oStDone(st_done1),
        .iKwValid(a_kw_valid), .oKwReady(kw_ready1), .iKwData(kw_data),
        .oKwData(kw_out1), .oKwDone(kw_done1), .oBusy(busy1), .oStallCnt(stall1));

    sbox_share_sched #(.NUM_SBOX(2)) u_dut2 (
        .iClk(clk), .iRsn(rst_n), .iStValid(a_st_valid), .oStReady(st_ready2),
        .iStData(st_data), .oStData(st_out2), .oStDone(st_done2),
        .iKwValid(a_kw_valid), .oKwReady(kw_ready2), .iKwData(kw_data),
        .oKwData(kw_out2), .oKwDone(kw_done2), .oBusy(busy2), .oStallCnt(stall2));

    int total = 0;
    int bad   = 0;
    logic [127:0] st_q [$];
    logic [31:0]  kw_q [$];
    logic [7:0]   ref_tab [256];

`ifdef SBOX_SHARE_PERF_EN
    localparam logic [15:0] EXP_STALL = 16'd6;
`else
    localparam logic [15:0] EXP_STALL = 16'd0;
`endif

    // Carry-less product then polynomial reduction
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
        for (int k = 14; k >= 8; k--) if (p[k]) p = p ^ (15'h11b << (k - 8));
        return p[7:0];
    endfunction

    // Build the S-box table by brute-force inverse search plus bitwise affine
    task automatic init_ref();
        logic [7:0] inv, s, c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (ref_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            ref_tab[x] = s;
        end
    endtask

    function automatic logic [127:0] ref_sub128(input logic [127:0] d);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = ref_tab[d[8*k +: 8]];
        return r;
    endfunction

    function automatic logic [31:0] ref_sub32(input logic [31:0] d);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = ref_tab[d[8*k +: 8]];
        return r;
    endfunction

    task automatic test_reset();
        rst_n = 0; st_valid = 0; kw_valid = 0; a_st_valid = 0; a_kw_valid = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (st_out !== '0) begin bad++; $display("FAIL reset_st_data got=%h want=0", st_out); end
        total++; if (kw_out !== '0) begin bad++; $display("FAIL reset_kw_data got=%h want=0", kw_out); end
        total++; if ({st_done, kw_done, busy, st_ready, kw_ready} !== 5'b0) begin
            bad++; $display("FAIL reset_flags got=%b want=00000", {st_done, kw_done, busy, st_ready, kw_ready}); end
        total++; if (stall_cnt !== 16'h0) begin bad++; $display("FAIL reset_stall got=%0d want=0", stall_cnt); end
        total++; if ((st_out1 | st_out2) !== '0 || {kw_out1, kw_out2} !== '0 || {busy1, busy2} !== 2'b0
                     || (stall1 | stall2) !== 16'h0) begin
            bad++; $display("FAIL reset_aux got=%h/%h busy=%b%b want=0", st_out1, st_out2, busy1, busy2); end
        @(posedge clk); #1 rst_n = 1;
    endtask

    task automatic test_basic_st();
        logic [127:0] d;
        int l4, l1, l2;
        d = 128'h0f0e0d0c0b0a09080706050403020100;
        l4 = -1; l1 = -1; l2 = -1;
        @(posedge clk); #1 st_valid = 1; a_st_valid = 1; st_data = d;
        @(negedge clk);
        total++; if ({st_ready, st_ready1, st_ready2} !== 3'b111) begin
            bad++; $display("FAIL st_accept got=%b want=111", {st_ready, st_ready1, st_ready2}); end
        if (st_ready) st_q.push_back(ref_sub128(d));
        @(posedge clk); #1 st_valid = 0; a_st_valid = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (l4 > 0 && c == l4 + 1) begin
                total++; if (st_done !== 1'b0) begin bad++; $display("FAIL st_done_pulse got=%b want=0", st_done); end
            end
            if (st_done && l4 < 0) begin
                l4 = c;
                total++;
                if (st_q.size() == 0) begin bad++; $display("FAIL st_sb_empty got=done want=no_done"); end
                else begin
                    logic [127:0] e;
                    e = st_q.pop_front();
                    if (st_out !== e) begin bad++; $display("FAIL st_data4 got=%h want=%h", st_out, e); end
                end
                total++; if (st_out !== 128'h76abd7fe2b670130c56f6bf27b777c63) begin
                    bad++; $display("FAIL st_const4 got=%h want=76abd7fe2b670130c56f6bf27b777c63", st_out); end
            end
            if (st_done1 && l1 < 0) begin
                l1 = c;
                total++; if (st_out1 !== 128'h76abd7fe2b670130c56f6bf27b777c63) begin
                    bad++; $display("FAIL st_data1 got=%h want=76abd7fe2b670130c56f6bf27b777c63", st_out1); end
            end
            if (st_done2 && l2 < 0) begin
                l2 = c;
                total++; if (st_out2 !== 128'h76abd7fe2b670130c56f6bf27b777c63) begin
                    bad++; $display("FAIL st_data2 got=%h want=76abd7fe2b670130c56f6bf27b777c63", st_out2); end
            end
        end
        total++; if (l4 != 5)  begin bad++; $display("FAIL st_lat4 got=%0d want=5", l4); end
        total++; if (l1 != 17) begin bad++; $display("FAIL st_lat1 got=%0d want=17", l1); end
        total++; if (l2 != 9)  begin bad++; $display("FAIL st_lat2 got=%0d want=9", l2); end
    endtask

    task automatic test_basic_kw();
        logic [31:0] d;
        int l4, l1, l2;
        d = 32'hcf4f3c09;
        l4 = -1; l1 = -1; l2 = -1;
        @(posedge clk); #1 kw_valid = 1; a_kw_valid = 1; kw_data = d;
        @(negedge clk);
        total++; if ({kw_ready, kw_ready1, kw_ready2} !== 3'b111) begin
            bad++; $display("FAIL kw_accept got=%b want=111", {kw_ready, kw_ready1, kw_ready2}); end
        if (kw_ready) kw_q.push_back(ref_sub32(d));
        @(posedge clk); #1 kw_valid = 0; a_kw_valid = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (kw_done && l4 < 0) begin
                l4 = c;
                total++;
                if (kw_q.size() == 0) begin bad++; $display("FAIL kw_sb_empty got=done want=no_done"); end
                else begin
                    logic [31:0] e;
                    e = kw_q.pop_front();
                    if (kw_out !== e) begin bad++; $display("FAIL kw_data4 got=%h want=%h", kw_out, e); end
                end
                total++; if (kw_out !== 32'h8a84eb01) begin bad++; $display("FAIL kw_const4 got=%h want=8a84eb01", kw_out); end
            end
            if (kw_done1 && l1 < 0) begin
                l1 = c;
                total++; if (kw_out1 !== 32'h8a84eb01) begin bad++; $display("FAIL kw_data1 got=%h want=8a84eb01", kw_out1); end
            end
            if (kw_done2 && l2 < 0) begin
                l2 = c;
                total++; if (kw_out2 !== 32'h8a84eb01) begin bad++; $display("FAIL kw_data2 got=%h want=8a84eb01", kw_out2); end
            end
        end
        total++; if (l4 != 2) begin bad++; $display("FAIL kw_lat4 got=%0d want=2", l4); end
        total++; if (l1 != 5) begin bad++; $display("FAIL kw_lat1 got=%0d want=5", l1); end
        total++; if (l2 != 3) begin bad++; $display("FAIL kw_lat2 got=%0d want=3", l2); end
        total++; if (st_out !== 128'h76abd7fe2b670130c56f6bf27b777c63 || st_out1 !== st_out2 || st_out2 !== 128'h76abd7fe2b670130c56f6bf27b777c63) begin
            bad++; $display("FAIL kw_st_hold got=%h want=76abd7fe2b670130c56f6bf27b777c63", st_out); end
    endtask

    task automatic test_contention();
        int grants [$];
        int exp_order [4];
        logic st_acc, kw_acc;
        exp_order = '{1, 0, 1, 0};
        @(posedge clk); #1 rst_n = 0;
        @(posedge clk); #1 rst_n = 1;
        st_valid = 1; kw_valid = 1;
        st_data = {$urandom, $urandom, $urandom, $urandom}; kw_data = $urandom;
        for (int c = 0; c < 80; c++) begin
            if (grants.size() >= 4 && st_q.size() == 0 && kw_q.size() == 0) break;
            @(negedge clk);
            st_acc = st_valid & st_ready;
            kw_acc = kw_valid & kw_ready;
            total++; if (st_ready && kw_ready) begin bad++; $display("FAIL both_ready got=11 want=not_both"); end
            if (st_acc) begin st_q.push_back(ref_sub128(st_data)); grants.push_back(0); end
            if (kw_acc) begin kw_q.push_back(ref_sub32(kw_data));  grants.push_back(1); end
            if (st_done) begin
                total++;
                if (st_q.size() == 0) begin bad++; $display("FAIL cont_st_empty got=done want=no_done"); end
                else begin
                    logic [127:0] e;
                    e = st_q.pop_front();
                    if (st_out !== e) begin bad++; $display("FAIL cont_st_data got=%h want=%h", st_out, e); end
                end
            end
            if (kw_done) begin
                total++;
                if (kw_q.size() == 0) begin bad++; $display("FAIL cont_kw_empty got=done want=no_done"); end
                else begin
                    logic [31:0] e;
                    e = kw_q.pop_front();
                    if (kw_out !== e) begin bad++; $display("FAIL cont_kw_data got=%h want=%h", kw_out, e); end
                end
            end
            @(posedge clk); #1;
            if (st_acc) st_data = {$urandom, $urandom, $urandom, $urandom};
            if (kw_acc) kw_data = $urandom;
            if (grants.size() >= 4) begin st_valid = 0; kw_valid = 0; end
        end
        total++; if (grants.size() != 4) begin bad++; $display("FAIL cont_grants got=%0d want=4", grants.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < grants.size()) begin
                total++; if (grants[i] != exp_order[i]) begin
                    bad++; $display("FAIL cont_order[%0d] got=%0d want=%0d (1=KW)", i, grants[i], exp_order[i]); end
            end
        end
        total++; if (st_q.size() != 0 || kw_q.size() != 0) begin
            bad++; $display("FAIL cont_pending got=%0d/%0d want=0/0", st_q.size(), kw_q.size()); end
        st_q.delete(); kw_q.delete();
    endtask

    task automatic test_capture_b2b();
        int acc_n, done_n, done_c;
        acc_n = 0; done_n = 0; done_c = -100;
        @(posedge clk); #1 st_valid = 1; st_data = 128'h00112233445566778899aabbccddeeff;
        for (int c = 0; c < 40; c++) begin
            if (done_n >= 2) break;
            @(negedge clk);
            if (st_done) begin
                total++;
                if (st_q.size() == 0) begin bad++; $display("FAIL cap_empty got=done want=no_done"); end
                else begin
                    logic [127:0] e;
                    e = st_q.pop_front();
                    if (st_out !== e) begin bad++; $display("FAIL cap_data got=%h want=%h", st_out, e); end
                end
                done_n++; done_c = c;
            end
            if (st_valid && st_ready) begin
                acc_n++;
                st_q.push_back(ref_sub128(st_data));
                if (acc_n == 2) begin
                    total++; if (c != done_c + 1) begin
                        bad++; $display("FAIL b2b_accept got=cycle%0d want=cycle%0d", c, done_c + 1); end
                end
            end
            @(posedge clk); #1;
            if (acc_n >= 2) st_valid = 0;
            st_data = {$urandom, $urandom, $urandom, $urandom};
        end
        total++; if (done_n != 2) begin bad++; $display("FAIL cap_done_cnt got=%0d want=2", done_n); end
        st_valid = 0; st_q.delete();
    endtask

    task automatic test_reset_midjob();
        logic seen_done;
        int kw_seen;
        seen_done = 0; kw_seen = 0;
        @(posedge clk); #1 st_valid = 1; st_data = 128'hdeadbeef_01234567_89abcdef_f0e1d2c3;
        @(negedge clk);
        total++; if (st_ready !== 1'b1) begin bad++; $display("FAIL mid_accept got=%b want=1", st_ready); end
        repeat (3) @(posedge clk);
        #1 st_valid = 0; rst_n = 0;
        #1;
        total++; if (st_out !== '0 || kw_out !== '0) begin
            bad++; $display("FAIL mid_rst_data got=%h/%h want=0/0", st_out, kw_out); end
        total++; if ({busy, st_done, kw_done} !== 3'b0 || stall_cnt !== 16'h0) begin
            bad++; $display("FAIL mid_rst_flags got=%b stall=%0d want=000 stall=0", {busy, st_done, kw_done}, stall_cnt); end
        @(posedge clk); #1 rst_n = 1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (st_done) seen_done = 1;
        end
        total++; if (seen_done) begin bad++; $display("FAIL mid_no_done got=done want=no_done"); end
        @(posedge clk); #1 st_valid = 1; kw_valid = 1; kw_data = 32'h53007c10;
        @(negedge clk);
        total++; if ({kw_ready, st_ready} !== 2'b10) begin
            bad++; $display("FAIL mid_kw_first got=%b want=10", {kw_ready, st_ready}); end
        if (kw_ready) kw_q.push_back(ref_sub32(kw_data));
        @(posedge clk); #1 st_valid = 0; kw_valid = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (kw_done && kw_seen == 0) begin
                kw_seen = 1;
                total++;
                if (kw_q.size() == 0) begin bad++; $display("FAIL mid_kw_empty got=done want=no_done"); end
                else begin
                    logic [31:0] e;
                    e = kw_q.pop_front();
                    if (kw_out !== e) begin bad++; $display("FAIL mid_kw_data got=%h want=%h", kw_out, e); end
                end
            end
        end
        total++; if (kw_seen == 0) begin bad++; $display("FAIL mid_kw_done got=none want=done"); end
        kw_q.delete();
    endtask

    task automatic test_perf();
        int kw_acc_seen, kw_done_seen;
        kw_acc_seen = 0; kw_done_seen = 0;
        @(posedge clk); #1 rst_n = 0;
        @(posedge clk); #1 rst_n = 1;
        // solo key-word job leaves last grant on KW so the state path wins next
        kw_valid = 1; kw_data = 32'h11223344;
        @(negedge clk);
        @(posedge clk); #1 kw_valid = 0;
        repeat (3) @(posedge clk);
        #1 st_valid = 1; kw_valid = 1; st_data = 128'h0123456789abcdeffedcba9876543210; kw_data = 32'ha5a55a5a;
        @(negedge clk);
        total++; if ({st_ready, kw_ready} !== 2'b10) begin
            bad++; $display("FAIL perf_st_first got=%b want=10", {st_ready, kw_ready}); end
        if (st_ready) st_q.push_back(ref_sub128(st_data));
        @(posedge clk); #1 st_valid = 0;
        for (int c = 1; c < 20; c++) begin
            if (kw_done_seen != 0) break;
            @(negedge clk);
            if (st_done) begin
                total++;
                if (st_q.size() == 0) begin bad++; $display("FAIL perf_st_empty got=done want=no_done"); end
                else begin
                    logic [127:0] e;
                    e = st_q.pop_front();
                    if (st_out !== e) begin bad++; $display("FAIL perf_st_data got=%h want=%h", st_out, e); end
                end
            end
            if (kw_done) begin
                kw_done_seen = 1;
                total++;
                if (kw_q.size() == 0) begin bad++; $display("FAIL perf_kw_empty got=done want=no_done"); end
                else begin
                    logic [31:0] e;
                    e = kw_q.pop_front();
                    if (kw_out !== e) begin bad++; $display("FAIL perf_kw_data got=%h want=%h", kw_out, e); end
                end
            end
            if (kw_valid && kw_ready) begin
                kw_acc_seen = 1;
                kw_q.push_back(ref_sub32(kw_data));
                total++; if (stall_cnt !== EXP_STALL) begin
                    bad++; $display("FAIL perf_stall got=%0d want=%0d", stall_cnt, EXP_STALL); end
            end
            @(posedge clk); #1;
            if (kw_acc_seen != 0) kw_valid = 0;
        end
        total++; if (kw_done_seen == 0) begin bad++; $display("FAIL perf_kw_done got=none want=done"); end
        @(negedge clk);
        total++; if (stall_cnt !== EXP_STALL) begin
            bad++; $display("FAIL perf_stall_hold got=%0d want=%0d", stall_cnt, EXP_STALL); end
        st_q.delete(); kw_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        init_ref();
        test_reset();
        test_basic_st();
        test_basic_kw();
        test_contention();
        test_capture_b2b();
        test_reset_midjob();
        test_perf();
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
